// File: rtl/serial_pkg.sv
// Shared types and width helpers for the bit serializer.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Bits needed to count 0..width-1; never less than one.
   function automatic int bitcnt_w(input int width);
      int w;
      w = 1;
      for (int i = 0; i < 6; i++) begin
         if ((1 << w) < width) w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-word valid/ready handshake feeding the serializer.
interface bit_serializer_if #(
   parameter int WIDTH = 5
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/skid_hold.sv
// One-entry holding register: accepts a word when empty, releases it on drain.
module skid_hold #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_drain,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;
   logic             w_accept;

   // Accept needs an empty entry and drain needs a full one, so they never coincide.
   assign w_accept = i_valid && !r_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full <= 1'b0;
      end else if (w_accept) begin
         r_full <= 1'b1;
      end else if (i_drain) begin
         r_full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_data <= i_din;
   end

   assign o_ready = !r_full;
   assign o_data  = r_data;
   assign o_full  = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: buffers one word and shifts it out a bit per clock.
module bit_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = 5,
   parameter int MSB_FIRST = 1,
   parameter int GAP       = 0
) (
   input  logic              clk,
   input  logic              rst,
   bit_serializer_if.slave   s_in,
   output logic              a,
   output logic              a_valid,
   output logic              word_done,
   output logic              busy
);

   localparam int                   BITCNT_W = bitcnt_w(WIDTH);
   localparam logic [BITCNT_W-1:0]  BIT_LAST = BITCNT_W'(WIDTH - 1);
   localparam logic [3:0]           GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t              r_state;
   state_t              w_next;
   logic [BITCNT_W-1:0] r_bit_cnt;
   logic [3:0]          r_gap_cnt;
   logic [WIDTH-1:0]    r_shift;
   logic [WIDTH-1:0]    w_hold;
   logic                w_full;
   logic                w_last;
   logic                w_gap_end;
   logic                w_load;
   logic                w_bit;

   skid_hold #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .i_din   (s_in.din),
      .i_valid (s_in.din_valid),
      .o_ready (s_in.din_ready),
      .i_drain (w_load),
      .o_data  (w_hold),
      .o_full  (w_full)
   );

   assign w_last    = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);
   assign w_gap_end = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_full) w_next = ST_SHIFT;
         ST_SHIFT: begin
            if (w_last) begin
               if (GAP > 0)     w_next = ST_GAP;
               else if (w_full) w_next = ST_SHIFT;
               else             w_next = ST_IDLE;
            end
         end
         ST_GAP:   if (w_gap_end) w_next = w_full ? ST_SHIFT : ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // A reload happens on every entry into SHIFT, including SHIFT->SHIFT at a word boundary.
   assign w_load = w_full && (w_next == ST_SHIFT) && ((r_state != ST_SHIFT) || w_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         if (w_load)                     r_bit_cnt <= '0;
         else if (r_state == ST_SHIFT)   r_bit_cnt <= r_bit_cnt + 1'b1;
         if (w_last)                     r_gap_cnt <= '0;
         else if (r_state == ST_GAP)     r_gap_cnt <= r_gap_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_load) begin
         r_shift <= w_hold;
      end else if (r_state == ST_SHIFT) begin
         if (MSB_FIRST != 0) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
         else                r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      end
   end

   assign w_bit = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];

   // Shift contents are not reset, so the serial bit is gated by the state.
   always_comb begin
      a_valid   = (r_state == ST_SHIFT);
      a         = (r_state == ST_SHIFT) && w_bit;
      word_done = w_last;
      busy      = (r_state != ST_IDLE) || w_full;
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three configurations checked against a queue-based stream model.
module tb_bit_serializer;

   typedef struct packed {
      logic v;
      logic b;
      logic d;
   } ent_t;

   logic       clk;
   logic       rst;
   logic [4:0] tb_din;
   logic       tb_valid;
   int         sel;

   int   total;
   int   bad;
   ent_t q[$];
   logic m_full;
   logic [4:0] m_word;
   int   m_msb;
   int   m_gap;

   logic a0, v0, d0, b0;
   logic a1, v1, d1, b1;
   logic a2, v2, d2, b2;
   logic o_a, o_v, o_d, o_b, o_r;

   bit_serializer_if #(.WIDTH(5)) if0 ();
   bit_serializer_if #(.WIDTH(5)) if1 ();
   bit_serializer_if #(.WIDTH(5)) if2 ();

   assign if0.din = tb_din;
   assign if1.din = tb_din;
   assign if2.din = tb_din;
   assign if0.din_valid = tb_valid && (sel == 0);
   assign if1.din_valid = tb_valid && (sel == 1);
   assign if2.din_valid = tb_valid && (sel == 2);

   bit_serializer #(.WIDTH(5), .MSB_FIRST(1), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .s_in(if0), .a(a0), .a_valid(v0), .word_done(d0), .busy(b0));
   bit_serializer #(.WIDTH(5), .MSB_FIRST(1), .GAP(3)) dut1 (
      .clk(clk), .rst(rst), .s_in(if1), .a(a1), .a_valid(v1), .word_done(d1), .busy(b1));
   bit_serializer #(.WIDTH(5), .MSB_FIRST(0), .GAP(0)) dut2 (
      .clk(clk), .rst(rst), .s_in(if2), .a(a2), .a_valid(v2), .word_done(d2), .busy(b2));

   always_comb begin
      o_a = a0; o_v = v0; o_d = d0; o_b = b0; o_r = if0.din_ready;
      if (sel == 1) begin
         o_a = a1; o_v = v1; o_d = d1; o_b = b1; o_r = if1.din_ready;
      end else if (sel == 2) begin
         o_a = a2; o_v = v2; o_d = d2; o_b = b2; o_r = if2.din_ready;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cfg=%0d observed=%b expected=%b t=%0t", tag, sel, obs, exp, $time);
      end
   endtask

   // A word entering the line becomes WIDTH data bits followed by GAP idle slots.
   task automatic push_word(input logic [4:0] w);
      ent_t e;
      for (int i = 0; i < 5; i++) begin
         e.v = 1'b1;
         e.b = (m_msb != 0) ? w[4 - i] : w[i];
         e.d = (i == 4);
         q.push_back(e);
      end
      for (int i = 0; i < m_gap; i++) q.push_back(ent_t'(3'b000));
   endtask

   task automatic model_edge();
      logic pre_full;
      if (!rst) begin
         q.delete();
         m_full = 1'b0;
      end else begin
         pre_full = m_full;
         if (q.size() > 0) void'(q.pop_front());
         if (pre_full && q.size() == 0) begin
            push_word(m_word);
            m_full = 1'b0;
         end
         if (tb_valid && !pre_full) begin
            m_full = 1'b1;
            m_word = tb_din;
         end
      end
   endtask

   task automatic tick();
      ent_t cur;
      @(negedge clk);
      cur = '0;
      if (q.size() > 0) cur = q[0];
      chk("a_valid",   o_v, cur.v);
      chk("a",         o_a, cur.b);
      chk("word_done", o_d, cur.d);
      chk("busy",      o_b, (q.size() > 0) || m_full);
      chk("din_ready", o_r, !m_full);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Present a word with valid high until the model says it was taken.
   task automatic put(input logic [4:0] w);
      logic took;
      int   n;
      tb_din   = w;
      tb_valid = 1'b1;
      n = 0;
      took = 1'b0;
      while (!took && n < 40) begin
         took = !m_full;
         tick();
         n++;
      end
      if (!took) begin
         total++;
         bad++;
         $error("FAIL accept_timeout cfg=%0d observed=0 expected=1", sel);
      end
   endtask

   task automatic idle(input int n);
      tb_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic rand_run(input int n);
      repeat (n) begin
         tb_valid = ($urandom_range(3) != 0);
         tb_din   = 5'($urandom);
         tick();
      end
      idle(20);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b0; tb_valid = 1'b0; tb_din = '0; sel = 0;
      m_full = 1'b0; m_word = '0; m_msb = 1; m_gap = 0;
      q.delete();

      tick(); tick();
      rst = 1'b1;
      idle(2);

      put(5'b10010);
      idle(10);

      put(5'b10010);
      put(5'b01001);
      idle(14);

      rand_run(80);

      // Reset in the middle of a word: outputs must drop without waiting for a clock.
      put(5'b10010);
      tb_valid = 1'b0;
      tick(); tick(); tick();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_a",         o_a, 1'b0);
      chk("rst_a_valid",   o_v, 1'b0);
      chk("rst_word_done", o_d, 1'b0);
      chk("rst_busy",      o_b, 1'b0);
      chk("rst_din_ready", o_r, 1'b1);
      q.delete();
      m_full = 1'b0;
      tick(); tick();
      rst = 1'b1;
      idle(10);

      sel = 1; m_msb = 1; m_gap = 3;
      put(5'b11111);
      put(5'b00001);
      idle(18);
      rand_run(80);

      sel = 2; m_msb = 0; m_gap = 0;
      put(5'b10010);
      idle(10);
      rand_run(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
